// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  Module   : dmem_arb_pkg
//  Brief    : Shared state encodings, master IDs and default widths for the
//             data-memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int c_DEF_AW = 10;
   localparam int c_DEF_DW = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
//  Module   : rr_pick2
//  Brief    : Combinational two-way round-robin picker; on a tie the master
//             that did not win last time is chosen.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] elig,
   input  logic       last,
   output logic       valid,
   output logic       winner
);

   always_comb begin
      valid  = |elig;
      winner = elig[1];
      if (elig == 2'b11) begin
         winner = (last == M1) ? M0 : M1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Round-robin req/ack arbiter for two masters sharing a 1-cycle
//             synchronous single-port data RAM. Optional statistics counters
//             are enabled with the ARB_STATS_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = c_DEF_AW,
   parameter int DW = c_DEF_DW
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]   stat_m0_grants,
   output logic [15:0]   stat_m1_grants,
   output logic [15:0]   stat_conflicts
`endif
);

   logic [1:0] r_state;
   logic [1:0] w_nextState;
   logic       r_owner;
   logic       r_we;
   logic       r_last;
   logic [1:0] w_elig;
   logic [1:0] w_cand;
   logic       w_pickValid;
   logic       w_winner;
   logic       w_load;
   logic       w_respond;

   // A request seen during its own ack cycle is the transaction just finished.
   assign w_elig = {m1_req & ~m1_ack, m0_req & ~m0_ack};

   always_comb begin
      w_cand = w_elig;
      if (r_state == ST_RESP) begin
         w_cand = w_elig & ((r_owner == M1) ? 2'b01 : 2'b10);
      end
   end

   rr_pick2 u_pick (
      .elig   (w_cand),
      .last   (r_last),
      .valid  (w_pickValid),
      .winner (w_winner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_nextState = w_pickValid ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: w_nextState = ST_RESP;
         ST_RESP:  w_nextState = w_pickValid ? ST_ISSUE : ST_IDLE;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load    = 1'b0;
      w_respond = 1'b0;
      case (r_state)
         ST_IDLE:  w_load = w_pickValid;
         ST_RESP: begin
            w_load    = w_pickValid;
            w_respond = 1'b1;
         end
         default: begin
            w_load    = 1'b0;
            w_respond = 1'b0;
         end
      endcase
   end

   // RAM-side and requester-side outputs are all registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner   <= M0;
         r_we      <= 1'b0;
         r_last    <= M1;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         if (w_respond) begin
            if (r_owner == M0) begin
               m0_ack <= 1'b1;
               if (!r_we) m0_rdata <= mem_rdata;
            end else begin
               m1_ack <= 1'b1;
               if (!r_we) m1_rdata <= mem_rdata;
            end
         end
         if (w_load) begin
            r_owner   <= w_winner;
            r_last    <= w_winner;
            r_we      <= (w_winner == M1) ? m1_we    : m0_we;
            mem_en    <= 1'b1;
            mem_we    <= (w_winner == M1) ? m1_we    : m0_we;
            mem_addr  <= (w_winner == M1) ? m1_addr  : m0_addr;
            mem_wdata <= (w_winner == M1) ? m1_wdata : m0_wdata;
         end
      end
   end

`ifdef ARB_STATS_EN
   // A conflict is a grant made while both candidates were competing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_m0_grants <= '0;
         stat_m1_grants <= '0;
         stat_conflicts <= '0;
      end else if (w_load) begin
         if (w_winner == M0 && stat_m0_grants != 16'hFFFF)
            stat_m0_grants <= stat_m0_grants + 16'd1;
         if (w_winner == M1 && stat_m1_grants != 16'hFFFF)
            stat_m1_grants <= stat_m1_grants + 16'd1;
         if (w_cand == 2'b11 && stat_conflicts != 16'hFFFF)
            stat_conflicts <= stat_conflicts + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Directed self-checking bench for dmem_arbiter with a 1-cycle RAM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [9:0]  m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [15:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
`ifdef ARB_STATS_EN
   logic [15:0] stat0, stat1, statc;
`endif

   logic [15:0] ram [0:1023];
   logic        preEn;
   logic [9:0]  preAddr;
   logic [15:0] preData;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_ack    (m0_ack),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_ack    (m1_ack),
      .m1_rdata  (m1_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
`ifdef ARB_STATS_EN
      .stat_m0_grants (stat0),
      .stat_m1_grants (stat1),
      .stat_conflicts (statc),
`endif
      .mem_rdata (mem_rdata)
   );

   // Synchronous RAM with a backdoor preload port used only during reset.
   always @(posedge clk) begin
      if (preEn) begin
         ram[preAddr] <= preData;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   function automatic logic [15:0] pat(input logic [9:0] a);
      case (a)
         10'h005: pat = 16'hBEEF;
         10'h010: pat = 16'h1111;
         10'h020: pat = 16'h2222;
         default: pat = {6'd0, a} ^ 16'hA5A5;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doAccess(input logic mst, input logic we, input logic [9:0] addr,
                           input logic [15:0] wd, output logic [15:0] rd);
      int n;
      if (mst == M1) begin
         m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
      end else begin
         m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
      end
      n = 0;
      do begin
         tick();
         n++;
      end while (!((mst == M1) ? m1_ack : m0_ack) && n < 20);
      check("access_timeout", 32'(n < 20), 32'd1);
      rd = (mst == M1) ? m1_rdata : m0_rdata;
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick();
   endtask

   initial begin
      logic [15:0] rd;
      int g, m0n, m1n, lastEn, cyc;

      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      preEn = 1'b1; preAddr = '0; preData = '0;
      #1;
      check("rst_m0_ack", m0_ack, 0);
      check("rst_m1_ack", m1_ack, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      check("rst_m1_rdata", m1_rdata, 0);
      for (int i = 0; i < 1024; i++) begin
         preAddr = 10'(i);
         preData = pat(10'(i));
         tick();
      end
      preEn = 1'b0;
      rst = 1'b0;
      tick();

      // Single uncontended M0 read
      m0_we = 1'b0; m0_addr = 10'h005; m0_req = 1'b1;
      tick();
      check("rd_mem_en", mem_en, 1);
      check("rd_mem_addr", mem_addr, 10'h005);
      check("rd_mem_we", mem_we, 0);
      tick();
      check("rd_mem_en_off", mem_en, 0);
      check("rd_ack_early", m0_ack, 0);
      tick();
      check("rd_ack", m0_ack, 1);
      check("rd_data", m0_rdata, 16'hBEEF);
      m0_req = 1'b0;
      tick();
      check("rd_ack_pulse", m0_ack, 0);
      check("rd_data_hold", m0_rdata, 16'hBEEF);

      // M1 write then M0 read-back
      doAccess(M1, 1'b1, 10'h3FF, 16'h1234, rd);
      check("wr_m1_rdata", m1_rdata, 0);
      check("wr_m0_rdata_hold", m0_rdata, 16'hBEEF);
      doAccess(M0, 1'b0, 10'h3FF, 16'h0000, rd);
      check("wr_readback", rd, 16'h1234);
      check("wr_m1_rdata2", m1_rdata, 0);

      // Simultaneous requests right after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      m0_we = 1'b0; m0_addr = 10'h010; m0_req = 1'b1;
      m1_we = 1'b0; m1_addr = 10'h020; m1_req = 1'b1;
      tick();
      check("tie_first_en", mem_en, 1);
      check("tie_first_addr", mem_addr, 10'h010);
      tick();
      check("tie_gap", mem_en, 0);
      tick();
      check("tie_m0_ack", m0_ack, 1);
      check("tie_m0_data", m0_rdata, 16'h1111);
      check("tie_second_en", mem_en, 1);
      check("tie_second_addr", mem_addr, 10'h020);
      m0_req = 1'b0;
      tick();
      check("tie_m1_ack_early", m1_ack, 0);
      tick();
      check("tie_m1_ack", m1_ack, 1);
      check("tie_m1_data", m1_rdata, 16'h2222);
      m1_req = 1'b0;
      tick();

      // Continuous contention: strict alternation, one access per 2 cycles
      m0_we = 1'b0; m0_addr = 10'h100; m0_req = 1'b1;
      m1_we = 1'b0; m1_addr = 10'h200; m1_req = 1'b1;
      g = 0; m0n = 0; m1n = 0; lastEn = -1; cyc = 0;
      while (!(m0n == 4 && m1n == 4) && cyc < 60) begin
         tick();
         cyc++;
         if (mem_en) begin
            check("alt_addr", 32'(mem_addr), g[0] ? 32'h200 + 32'(g / 2) : 32'h100 + 32'(g / 2));
            if (lastEn >= 0) check("alt_gap", 32'(cyc - lastEn), 32'd2);
            lastEn = cyc;
            g++;
         end
         if (m0_ack) begin
            check("alt_m0_data", m0_rdata, pat(10'(32'h100 + 32'(m0n))));
            m0n++;
            if (m0n == 4) m0_req = 1'b0;
            else          m0_addr = 10'(32'h100 + 32'(m0n));
         end
         if (m1_ack) begin
            check("alt_m1_data", m1_rdata, pat(10'(32'h200 + 32'(m1n))));
            m1n++;
            if (m1n == 4) m1_req = 1'b0;
            else          m1_addr = 10'(32'h200 + 32'(m1n));
         end
      end
      check("alt_timeout", 32'(cyc < 60), 32'd1);
      check("alt_grants", 32'(g), 32'd8);
      tick();
      tick();

      // Same master back-to-back with req held through the ack cycle
      m0_we = 1'b0; m0_addr = 10'h030; m0_req = 1'b1;
      tick();
      check("b2b_en1", mem_en, 1);
      check("b2b_addr1", mem_addr, 10'h030);
      tick();
      tick();
      check("b2b_ack1", m0_ack, 1);
      check("b2b_data1", m0_rdata, pat(10'h030));
      m0_addr = 10'h031;
      tick();
      check("b2b_no_regrant", mem_en, 0);
      check("b2b_ack_pulse", m0_ack, 0);
      tick();
      check("b2b_en2", mem_en, 1);
      check("b2b_addr2", mem_addr, 10'h031);
      tick();
      tick();
      check("b2b_ack2", m0_ack, 1);
      check("b2b_data2", m0_rdata, pat(10'h031));
      m0_req = 1'b0;
      tick();
      tick();

      // Reset while an M1 read is in ISSUE
      m1_we = 1'b0; m1_addr = 10'h040; m1_req = 1'b1;
      tick();
      check("rr_issue_en", mem_en, 1);
      rst = 1'b1;
      #1;
      check("rr_mem_en", mem_en, 0);
      check("rr_state", dut.r_state, ST_IDLE);
      check("rr_m1_ack", m1_ack, 0);
      check("rr_m1_rdata", m1_rdata, 0);
      m1_req = 1'b0;
      tick();
      tick();
      check("rr_m1_ack_hold", m1_ack, 0);
      check("rr_m0_ack_hold", m0_ack, 0);
`ifdef ARB_STATS_EN
      check("rr_stat_m0", stat0, 0);
      check("rr_stat_m1", stat1, 0);
      check("rr_stat_conf", statc, 0);
`endif
      rst = 1'b0;
      tick();
      m0_addr = 10'h050; m0_req = 1'b1;
      m1_addr = 10'h060; m1_req = 1'b1;
      tick();
      check("rr_tie_addr", mem_addr, 10'h050);
      tick();
      tick();
      check("rr_tie_m0_ack", m0_ack, 1);
      check("rr_tie_m1_ack", m1_ack, 0);
      m0_req = 1'b0;
      tick();
      tick();
      check("rr_tie_m1_ack2", m1_ack, 1);
      check("rr_tie_m1_data", m1_rdata, pat(10'h060));
      m1_req = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
